// File: rtl/m8_seq_pkg.sv
// Shared state encoding, field widths and default frame geometry for the M8 frame sequencer.
package m8_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_TICK,
    FETCH,
    CAPTURE
  } seq_state_e;

  localparam int WORD_W        = 12;
  localparam int PTR_W         = 10;
  localparam int GRP_W         = 5;
  localparam int WORD_DIV_DEF  = 16;
  localparam int FRAME_LEN_DEF = 1024;
  localparam int GRP_LEN_DEF   = 32;

endpackage

// File: rtl/m8_word_timer.sv
// Word-slot timer: free-running 0..WORD_DIV-1 counter, held at zero while clear_i is high.
module m8_word_timer
  import m8_seq_pkg::*;
#(
  parameter int WORD_DIV = WORD_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  output logic tick_o
);

  localparam int               CNT_W = $clog2(WORD_DIV);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WORD_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || (cnt_q == LAST)) cnt_d = '0;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick_o = !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/m8_frame_sequencer.sv
// M8 frame sequencer: word fetch strobe, frame pointer, group counter and valid/ready word hand-off.
// Define M8_SEQ_OVR_CNT_EN to add the saturating 8-bit overrun event counter output ovrCnt.
module m8_frame_sequencer
  import m8_seq_pkg::*;
#(
  parameter int WORD_DIV  = WORD_DIV_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int GRP_LEN   = GRP_LEN_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic              bufGetWord,
  output logic [PTR_W-1:0]  bufRdPointer,
  output logic [GRP_W-1:0]  cntGrp,
  input  logic [WORD_W-1:0] dataWord,
  output logic [WORD_W-1:0] wordOut,
  output logic              wordValid,
  input  logic              wordReady,
  output logic              frameStart,
  output logic              grpStart,
  output logic              running,
`ifdef M8_SEQ_OVR_CNT_EN
  output logic [7:0]        ovrCnt,
`endif
  output logic              overrun
);

  seq_state_e        state_q;
  logic              get_q;
  logic [PTR_W-1:0]  ptr_q;
  logic [PTR_W-1:0]  ptr_d;
  logic [GRP_W-1:0]  grp_q;
  logic [GRP_W-1:0]  grp_d;
  logic [WORD_W-1:0] word_q;
  logic              valid_q;
  logic              frame_start_q;
  logic              grp_start_q;
  logic              running_q;
  logic              overrun_q;
  logic              ptr_wrap;
  logic              tick;
`ifdef M8_SEQ_OVR_CNT_EN
  logic [7:0]        ovr_cnt_q;
`endif

  m8_word_timer #(
    .WORD_DIV (WORD_DIV)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear_i (state_q == IDLE),
    .tick_o  (tick)
  );

  always_comb begin
    ptr_wrap = (ptr_q == PTR_W'(FRAME_LEN - 1));
    ptr_d    = ptr_wrap ? '0 : ptr_q + 1'b1;
    grp_d    = grp_q;
    if (ptr_wrap) grp_d = (grp_q == GRP_W'(GRP_LEN - 1)) ? '0 : grp_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      get_q         <= 1'b0;
      ptr_q         <= '0;
      grp_q         <= '0;
      word_q        <= '0;
      valid_q       <= 1'b0;
      frame_start_q <= 1'b0;
      grp_start_q   <= 1'b0;
      running_q     <= 1'b0;
      overrun_q     <= 1'b0;
`ifdef M8_SEQ_OVR_CNT_EN
      ovr_cnt_q     <= '0;
`endif
    end else begin
      get_q <= 1'b0;

      // A slot tick with an unaccepted word means the serializer fell behind the frame clock.
      if (tick && valid_q) begin
        overrun_q <= 1'b1;
`ifdef M8_SEQ_OVR_CNT_EN
        if (ovr_cnt_q != 8'hFF) ovr_cnt_q <= ovr_cnt_q + 8'd1;
`endif
      end

      if (valid_q && wordReady) begin
        valid_q       <= 1'b0;
        frame_start_q <= 1'b0;
        grp_start_q   <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          ptr_q <= '0;
          grp_q <= '0;
          if (enable) begin
            state_q   <= WAIT_TICK;
            running_q <= 1'b1;
          end
        end
        WAIT_TICK: begin
          if (tick) begin
            state_q <= FETCH;
            get_q   <= 1'b1;
          end
        end
        FETCH: state_q <= CAPTURE;
        CAPTURE: begin
          // Written after the accept clear above, so a capture in the same cycle wins.
          word_q        <= dataWord;
          valid_q       <= 1'b1;
          frame_start_q <= (ptr_q == '0);
          grp_start_q   <= (ptr_q == '0) && (grp_q == '0);
          ptr_q         <= ptr_d;
          grp_q         <= grp_d;
          if (ptr_wrap && !enable) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
          end else begin
            state_q <= WAIT_TICK;
          end
        end
        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign bufGetWord   = get_q;
  assign bufRdPointer = ptr_q;
  assign cntGrp       = grp_q;
  assign wordOut      = word_q;
  assign wordValid    = valid_q;
  assign frameStart   = frame_start_q;
  assign grpStart     = grp_start_q;
  assign running      = running_q;
  assign overrun      = overrun_q;
`ifdef M8_SEQ_OVR_CNT_EN
  assign ovrCnt       = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_m8_frame_sequencer.sv
// Self-checking bench for m8_frame_sequencer: directed vector table, small-geometry group wrap,
// async reset mid-fetch, and a long randomized run against a slot-arithmetic reference model.
module tb_m8_frame_sequencer;

  localparam int W   = 16;
  localparam int FL  = 1024;
  localparam int GL  = 32;
  localparam int SW  = 4;
  localparam int SFL = 4;
  localparam int SGL = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        word_ready = 1'b0;
  logic [11:0] data_word = '0;
  logic        bufGetWord;
  logic [9:0]  bufRdPointer;
  logic [4:0]  cntGrp;
  logic [11:0] wordOut;
  logic        wordValid, frameStart, grpStart, running, overrun;

  logic        s_en = 1'b0;
  logic        s_ready = 1'b0;
  logic [11:0] s_data = '0;
  logic        s_get;
  logic [9:0]  s_ptr;
  logic [4:0]  s_grp;
  logic [11:0] s_wout;
  logic        s_valid, s_fs, s_gs, s_run, s_ovr;
`ifdef M8_SEQ_OVR_CNT_EN
  logic [7:0]  ovr_cnt;
  logic [7:0]  s_ovr_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  m8_frame_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .bufGetWord   (bufGetWord),
    .bufRdPointer (bufRdPointer),
    .cntGrp       (cntGrp),
    .dataWord     (data_word),
    .wordOut      (wordOut),
    .wordValid    (wordValid),
    .wordReady    (word_ready),
    .frameStart   (frameStart),
    .grpStart     (grpStart),
    .running      (running),
`ifdef M8_SEQ_OVR_CNT_EN
    .ovrCnt       (ovr_cnt),
`endif
    .overrun      (overrun)
  );

  m8_frame_sequencer #(
    .WORD_DIV  (SW),
    .FRAME_LEN (SFL),
    .GRP_LEN   (SGL)
  ) dut_small (
    .clk          (clk),
    .reset        (reset),
    .enable       (s_en),
    .bufGetWord   (s_get),
    .bufRdPointer (s_ptr),
    .cntGrp       (s_grp),
    .dataWord     (s_data),
    .wordOut      (s_wout),
    .wordValid    (s_valid),
    .wordReady    (s_ready),
    .frameStart   (s_fs),
    .grpStart     (s_gs),
    .running      (s_run),
`ifdef M8_SEQ_OVR_CNT_EN
    .ovrCnt       (s_ovr_cnt),
`endif
    .overrun      (s_ovr)
  );

  typedef struct {
    bit          rst;
    bit          en;
    bit          rdy;
    logic [11:0] data;
    int          n;
    bit          get;
    int          ptr;
    int          grp;
    bit          valid;
    logic [11:0] word;
    bit          fs;
    bit          gs;
    bit          run;
    bit          ovr;
    int          cnt;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_main(input string tag, input bit get, input int ptr, input int grp,
                            input bit valid, input logic [11:0] word, input bit fs, input bit gs,
                            input bit run, input bit ovr);
    check({tag, ".get"},   32'(bufGetWord),   32'(get));
    check({tag, ".ptr"},   32'(bufRdPointer), ptr);
    check({tag, ".grp"},   32'(cntGrp),       grp);
    check({tag, ".valid"}, 32'(wordValid),    32'(valid));
    check({tag, ".word"},  32'(wordOut),      32'(word));
    check({tag, ".fs"},    32'(frameStart),   32'(fs));
    check({tag, ".gs"},    32'(grpStart),     32'(gs));
    check({tag, ".run"},   32'(running),      32'(run));
    check({tag, ".ovr"},   32'(overrun),      32'(ovr));
  endtask

  // Small geometry: group wrap, constant fetched word 12'hA5C, random ready, hold stability.
  task automatic run_small();
    bit          hold;
    logic [11:0] prev_word;
    hold = 1'b0;
    prev_word = '0;
    s_en = 1'b1;
    s_ready = 1'b1;
    step(1);
    for (int r = 0; r < SW * 40; r++) begin
      if (r >= SW + 2 && (r - 2) % SW == 0) begin
        int j;
        j = (r - 2) / SW;
        check($sformatf("small.r%0d.valid", r), 32'(s_valid), 32'd1);
        check($sformatf("small.r%0d.word", r),  32'(s_wout),  32'h0A5C);
        check($sformatf("small.r%0d.ptr", r),   32'(s_ptr),   j % SFL);
        check($sformatf("small.r%0d.grp", r),   32'(s_grp),   (j / SFL) % SGL);
        check($sformatf("small.r%0d.fs", r),    32'(s_fs),    32'(((j - 1) % SFL) == 0));
        check($sformatf("small.r%0d.gs", r),    32'(s_gs),    32'(((j - 1) % (SFL * SGL)) == 0));
      end
      if (hold) check($sformatf("small.r%0d.hold", r), 32'(s_wout), 32'(prev_word));
      if (s_valid && s_ready) check($sformatf("small.r%0d.accept", r), 32'(s_wout), 32'h0A5C);
      hold = s_valid && !s_ready && !(r >= SW + 1 && r % SW == 1);
      prev_word = s_wout;
      s_ready = 1'($urandom_range(0, 1));
      s_data = (r >= SW + 1 && r % SW == 1) ? 12'hA5C : 12'($urandom);
      step(1);
    end
    s_en = 1'b0;
  endtask

  // Reference: with r counted from the first non-IDLE cycle, ticks fall at r%W==W-1, fetches at
  // r%W==0 (r>=W), captures at the end of r%W==1 (r>=W+1); words captured so far = (r-2)/W.
  task automatic run_model();
    bit          m_valid, m_fs, m_gs, m_ovr, done;
    logic [11:0] m_word, fetched;
    int          r, k, idx;
`ifdef M8_SEQ_OVR_CNT_EN
    int          m_cnt;
    m_cnt = 0;
`endif
    m_valid = 0; m_fs = 0; m_gs = 0; m_ovr = 0; done = 0;
    m_word = '0; fetched = '0;
    enable = 1'b1;
    word_ready = 1'b1;
    data_word = 12'($urandom);
    step(1);
    r = 0;
    while (!done && errors < 50 && r < 40000) begin
      k = (r >= W + 2) ? (r - 2) / W : 0;
      check_main($sformatf("model.r%0d", r), (r >= W) && (r % W == 0), k % FL, (k / FL) % GL,
                 m_valid, m_word, m_fs, m_gs, 1'b1, m_ovr);
`ifdef M8_SEQ_OVR_CNT_EN
      check($sformatf("model.r%0d.cnt", r), 32'(ovr_cnt), m_cnt);
`endif
      word_ready = ($urandom_range(0, 3) != 0);
      if (r >= W + 1 && r % W == 1) begin
        fetched = 12'($urandom);
        data_word = fetched;
      end else begin
        data_word = 12'($urandom);
      end
      if (k == FL + 500) enable = 1'b0;
      if (r % W == W - 1 && m_valid) begin
        m_ovr = 1'b1;
`ifdef M8_SEQ_OVR_CNT_EN
        if (m_cnt < 255) m_cnt++;
`endif
      end
      if (r >= W + 1 && r % W == 1) begin
        idx = (r - 1) / W - 1;
        m_valid = 1'b1;
        m_word = fetched;
        m_fs = (idx % FL == 0);
        m_gs = (idx % (FL * GL) == 0);
        if (idx % FL == FL - 1 && !enable) done = 1'b1;
      end else if (m_valid && word_ready) begin
        m_valid = 1'b0;
        m_fs = 1'b0;
        m_gs = 1'b0;
      end
      step(1);
      r++;
    end
    check("model.done", 32'(done), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int gets;

    //          rst en rdy data     n   get ptr grp val word     fs gs run ovr cnt
    tbl[0]  = '{1, 0, 1, 12'h000, 2,  0,  0,  0,  0, 12'h000, 0, 0, 0,  0,  0};
    tbl[1]  = '{0, 0, 1, 12'h000, 3,  0,  0,  0,  0, 12'h000, 0, 0, 0,  0,  0};
    tbl[2]  = '{0, 1, 1, 12'h3C1, 1,  0,  0,  0,  0, 12'h000, 0, 0, 1,  0,  0};
    tbl[3]  = '{0, 1, 1, 12'h3C1, 15, 0,  0,  0,  0, 12'h000, 0, 0, 1,  0,  0};
    tbl[4]  = '{0, 1, 1, 12'h3C1, 1,  1,  0,  0,  0, 12'h000, 0, 0, 1,  0,  0};
    tbl[5]  = '{0, 1, 1, 12'h3C1, 1,  0,  0,  0,  0, 12'h000, 0, 0, 1,  0,  0};
    tbl[6]  = '{0, 1, 1, 12'h3C1, 1,  0,  1,  0,  1, 12'h3C1, 1, 1, 1,  0,  0};
    tbl[7]  = '{0, 1, 1, 12'h3C1, 1,  0,  1,  0,  0, 12'h3C1, 0, 0, 1,  0,  0};
    tbl[8]  = '{0, 1, 0, 12'h111, 16, 0,  2,  0,  1, 12'h111, 0, 0, 1,  0,  0};
    tbl[9]  = '{0, 1, 0, 12'h222, 13, 1,  2,  0,  1, 12'h111, 0, 0, 1,  1,  1};
    tbl[10] = '{0, 1, 0, 12'h222, 2,  0,  3,  0,  1, 12'h222, 0, 0, 1,  1,  1};
    tbl[11] = '{0, 1, 1, 12'h222, 1,  0,  3,  0,  0, 12'h222, 0, 0, 1,  1,  1};
    tbl[12] = '{0, 1, 1, 12'h222, 20, 0,  4,  0,  0, 12'h222, 0, 0, 1,  1,  1};
    tbl[13] = '{1, 0, 1, 12'h000, 1,  0,  0,  0,  0, 12'h000, 0, 0, 0,  0,  0};

    for (int i = 0; i < 14; i++) begin
      reset = tbl[i].rst;
      enable = tbl[i].en;
      word_ready = tbl[i].rdy;
      data_word = tbl[i].data;
      step(tbl[i].n);
      check_main($sformatf("tbl%0d", i), tbl[i].get, tbl[i].ptr, tbl[i].grp, tbl[i].valid,
                 tbl[i].word, tbl[i].fs, tbl[i].gs, tbl[i].run, tbl[i].ovr);
`ifdef M8_SEQ_OVR_CNT_EN
      check($sformatf("tbl%0d.cnt", i), 32'(ovr_cnt), tbl[i].cnt);
`endif
    end

    reset = 1'b0;
    enable = 1'b0;
    step(1);
    run_small();

    // Asynchronous reset in the middle of the fetch of pointer 300.
    enable = 1'b1;
    word_ready = 1'b1;
    data_word = 12'h055;
    found = 1'b0;
    for (int i = 0; i < 6000 && !found; i++) begin
      step(1);
      if (bufGetWord && bufRdPointer == 10'd300) found = 1'b1;
    end
    check("reach_fetch_ptr300", 32'(found), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_main("async_rst", 0, 0, 0, 0, 12'h000, 0, 0, 0, 0);
    step(1);
    check_main("rst_held", 0, 0, 0, 0, 12'h000, 0, 0, 0, 0);
    reset = 1'b0;
    enable = 1'b1;
    step(17);
    check("restart.get", 32'(bufGetWord), 32'd1);
    check("restart.ptr", 32'(bufRdPointer), 32'd0);
    check("restart.grp", 32'(cntGrp), 32'd0);
    step(2);
    check("restart.valid", 32'(wordValid), 32'd1);
    check("restart.fs", 32'(frameStart), 32'd1);
    check("restart.gs", 32'(grpStart), 32'd1);

    // Randomized run over two frames, dropping enable at pointer 500 of the second frame.
    reset = 1'b1;
    enable = 1'b0;
    step(1);
    reset = 1'b0;
    step(1);
    run_model();
    check("stop.run", 32'(running), 32'd0);
    check("stop.ptr", 32'(bufRdPointer), 32'd0);
    check("stop.grp", 32'(cntGrp), 32'd2);
    check("stop.valid", 32'(wordValid), 32'd1);
    enable = 1'b0;
    step(1);
    check("idle.grp", 32'(cntGrp), 32'd0);
    gets = 0;
    for (int i = 0; i < 3 * W; i++) begin
      step(1);
      if (bufGetWord) gets++;
    end
    check("idle.no_fetch", gets, 0);
    check("idle.run", 32'(running), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/m8_frame_sequencer.md
# m8_frame_sequencer

Sequences the M8 word filler. Generates the word-rate fetch strobe, the 10-bit buffer read pointer and the 5-bit group counter, captures the filler's 12-bit word and hands it to the downstream serializer with a valid/ready handshake. Sits between the frame timing source and the filler/serializer pair, and owns all frame and group timing for one M8 stream.

## Interface
- WORD_DIV, 16: clocks per word slot; legal range ≥ 4.
- FRAME_LEN, 1024: words per frame; pointer wraps at FRAME_LEN-1.
- GRP_LEN, 32: frames per group; cntGrp wraps at GRP_LEN-1.

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run request; sampled only at frame boundaries.
- bufGetWord  out  1  one-cycle fetch strobe to the filler.
- bufRdPointer  out  10  word index within the frame, 0..FRAME_LEN-1.
- cntGrp  out  5  frame index within the group, 0..GRP_LEN-1.
- dataWord  in  12  filler output, valid the cycle after bufGetWord.
- wordOut  out  12  captured word to the serializer.
- wordValid  out  1  wordOut valid; held until wordReady.
- wordReady  in  1  serializer accepts wordOut when high with wordValid.
- frameStart  out  1  high with wordValid for the word at pointer 0.
- grpStart  out  1  high with wordValid for pointer 0 and cntGrp 0.
- running  out  1  sequencer active (state ≠ IDLE).
- overrun  out  1  sticky: a slot tick arrived while wordValid was still pending.

## Operation
- States: IDLE, WAIT_TICK, FETCH, CAPTURE.
- IDLE: timer held at 0, pointer 0, cntGrp 0. When enable=1 -> WAIT_TICK.
- Word timer counts 0..WORD_DIV-1 continuously outside IDLE; tick when it equals WORD_DIV-1.
- WAIT_TICK + tick -> FETCH. FETCH drives bufGetWord=1 for exactly one cycle with the current bufRdPointer, then -> CAPTURE.
- CAPTURE: wordOut <= dataWord, wordValid <= 1, frameStart/grpStart set from the fetched pointer and cntGrp. Pointer advances here. -> WAIT_TICK.
- Pointer advance: pointer+1; at FRAME_LEN-1 wrap to 0 and cntGrp+1 (wrap at GRP_LEN-1 to 0). At wrap, if enable=0 -> IDLE after CAPTURE; otherwise continue. A started frame always completes.
- Handshake: wordValid cleared on the cycle wordValid & wordReady. wordOut stable while wordValid=1.
- Overrun: tick while wordValid=1 sets overrun. The old word is overwritten by the new capture and the pointer still advances, so frame timing never slips. overrun clears only on reset.
- Capture and accept in the same cycle: the capture wins and wordValid stays 1.

## Timing
- Reset values: bufGetWord 0, bufRdPointer 0, cntGrp 0, wordOut 0, wordValid 0, frameStart 0, grpStart 0, running 0, overrun 0. State IDLE, timer 0.
- Reset asserted mid-frame clears everything immediately. The filler sees bufGetWord=0 from that point.
- Tick at cycle T: bufGetWord high in T+1. Filler registers at the end of T+1. Capture at the end of T+2. wordValid high from T+3.
- Word slot period is exactly WORD_DIV clocks. Frame period is WORD_DIV·FRAME_LEN clocks.
- bufRdPointer changes only in CAPTURE. It is stable for the whole FETCH cycle.
- All outputs are registered.

## Configuration
- M8_SEQ_OVR_CNT_EN defined: adds output ovrCnt[7:0], which counts overrun events and saturates at 255. It clears on reset only.
- Not defined: no ovrCnt port. Only the sticky overrun flag exists.

## Structure
- Package m8_seq_pkg: state enum (IDLE, WAIT_TICK, FETCH, CAPTURE), default FRAME_LEN/GRP_LEN constants, word width 12, pointer width 10, group width 5.
- One sub-module: m8_word_timer, which holds the WORD_DIV counter and tick output and is cleared in IDLE.

## Test plan
- Reset, then enable=1, WORD_DIV=16, wordReady=1 -> first bufGetWord at cycle 16 after leaving IDLE with pointer 0. wordValid follows 2 cycles later with frameStart=1 and grpStart=1.
- Run 1024 words -> pointer wraps 1023->0, cntGrp 0->1. The next pointer-0 word has frameStart=1 and grpStart=0. Group wraps 31->0 after 32 frames.
- Hold wordReady=0 for 2 slots -> overrun=1, wordOut equals the latest capture, and pointer still advances by 2. With M8_SEQ_OVR_CNT_EN defined, ovrCnt=1.
- Drop enable at pointer 500 -> frame completes through 1023, then state is IDLE with running=0 and no further bufGetWord.
- Assert reset at pointer 300, mid-FETCH -> all outputs are at reset values in the same cycle. Restart begins at pointer 0, cntGrp 0.
- Drive dataWord=12'hA5C on each fetch and toggle wordReady with a random pattern -> every accepted wordOut is 12'hA5C, and wordOut never changes while wordValid=1 and wordReady=0 until the next tick.
